// File: rtl/pulse_window_counter_mc_if.sv
// Closed-window result stream, one beat per lane; out_peak exists only when PULSE_WIN_PEAK_EN is defined.
interface pulse_window_counter_mc_if #(
  parameter int LANE_W = 2,
`ifdef PULSE_WIN_PEAK_EN
  parameter int PEAK_W = 5,
`endif
  parameter int CNT_W  = 24
);
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_lane;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;
  logic [15:0]       out_win_id;
  logic              out_last;
`ifdef PULSE_WIN_PEAK_EN
  logic [PEAK_W-1:0] out_peak;

  modport master (output out_valid, out_lane, out_count, out_sat, out_win_id, out_last, out_peak,
                  input  out_ready);
  modport slave  (input  out_valid, out_lane, out_count, out_sat, out_win_id, out_last, out_peak,
                  output out_ready);
`else
  modport master (output out_valid, out_lane, out_count, out_sat, out_win_id, out_last,
                  input  out_ready);
  modport slave  (input  out_valid, out_lane, out_count, out_sat, out_win_id, out_last,
                  output out_ready);
`endif
endinterface

// File: rtl/pulse_window_counter_mc.sv
// Multi-lane windowed pulse counter; results visible the cycle after close, stalled by out_ready, dropped when full.
// PULSE_WIN_PEAK_EN adds a per-lane peak per-cycle count to each result beat.
module pulse_window_counter_mc #(
  parameter int NUM_LANES  = 4,
  parameter int IN_W       = 5,
  parameter int CNT_W      = 24,
  parameter int WIN_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  input  logic [NUM_LANES*IN_W-1:0] pulse_in_i,
  input  logic [WIN_W-1:0]          window_cycles_i,
  input  logic [1:0]                mode_i,
  input  logic                      count_enable_i,
  input  logic                      gate_i,
  output logic                      busy_o,
  output logic                      overflow_o,
  output logic [7:0]                drop_cnt_o,
  pulse_window_counter_mc_if.master res
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int SUM_W  = ((CNT_W > IN_W) ? CNT_W : IN_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [LANE_W-1:0] LAST_LN  = LANE_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic                 en_q, en_prev_q;
  logic [WIN_W-1:0]     win_cnt_q, win_last_q;
  logic [CNT_W-1:0]     acc_q [NUM_LANES];
  logic [NUM_LANES-1:0] sat_q;
  logic [15:0]          win_id_q;
  logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
  logic [LANE_W-1:0]    beat_q;
  logic                 overflow_q;
  logic [7:0]           drop_cnt_q;
  logic [CNT_W-1:0]     mem_cnt_q [FIFO_DEPTH][NUM_LANES];
  logic [NUM_LANES-1:0] mem_sat_q [FIFO_DEPTH];
  logic [15:0]          mem_id_q  [FIFO_DEPTH];

  logic                 rise, active, acc_en, close, push, pop, drop, fifo_full, fifo_empty;
  logic [WIN_W-1:0]     wc_last, cur_last;
  logic [PTR_W-1:0]     wr_idx, rd_idx;
  logic [SUM_W-1:0]     sum   [NUM_LANES];
  logic [CNT_W-1:0]     acc_d [NUM_LANES];
  logic [NUM_LANES-1:0] sat_d;

  assign rise     = en_q & ~en_prev_q;
  assign active   = (state_q == RUN && en_q) || (state_q == IDLE && rise);
  assign acc_en   = active & in_valid_i & ((mode_i != 2'd2) | gate_i);
  // A zero-length window behaves as length 1; the length is only picked up on a window's first cycle.
  assign wc_last  = (window_cycles_i == '0) ? '0 : window_cycles_i - WIN_W'(1);
  assign cur_last = (win_cnt_q == '0) ? wc_last : win_last_q;
  assign close    = active && (win_cnt_q == cur_last);

  assign wr_idx     = wr_ptr_q[PTR_W-1:0];
  assign rd_idx     = rd_ptr_q[PTR_W-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
  assign pop        = !fifo_empty && res.out_ready && (beat_q == LAST_LN);
  // Popping the last beat frees a slot in the same cycle, so a coincident close is kept.
  assign push       = close && (!fifo_full || pop);
  assign drop       = close && !push;

  always_comb begin
    sat_d = sat_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      sum[l] = SUM_W'(acc_q[l]);
      if (acc_en) sum[l] = sum[l] + SUM_W'(pulse_in_i[l*IN_W +: IN_W]);
      sat_d[l] = sat_q[l] | (sum[l] > SUM_W'(CNT_MAX));
      acc_d[l] = (sum[l] > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[l][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      en_prev_q  <= 1'b0;
      win_cnt_q  <= '0;
      win_last_q <= '0;
      sat_q      <= '0;
      win_id_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int l = 0; l < NUM_LANES; l++) acc_q[l] <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_sat_q[e] <= '0;
        mem_id_q[e]  <= '0;
        for (int l = 0; l < NUM_LANES; l++) mem_cnt_q[e][l] <= '0;
      end
    end else begin
      en_q      <= count_enable_i;
      en_prev_q <= en_q;
      case (state_q)
        IDLE:    if (rise) state_q <= (close && mode_i == 2'd1) ? DONE : RUN;
        RUN:     if (!en_q) state_q <= IDLE;
                 else if (close && mode_i == 2'd1) state_q <= DONE;
        DONE:    if (!en_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      win_cnt_q <= (active && !close) ? win_cnt_q + WIN_W'(1) : '0;
      if (active && win_cnt_q == '0) win_last_q <= wc_last;
      for (int l = 0; l < NUM_LANES; l++) acc_q[l] <= (active && !close) ? acc_d[l] : '0;
      sat_q <= (active && !close) ? sat_d : '0;
      if (close) win_id_q <= win_id_q + 16'd1;
      if (push) begin
        for (int l = 0; l < NUM_LANES; l++) mem_cnt_q[wr_idx][l] <= acc_d[l];
        mem_sat_q[wr_idx] <= sat_d;
        mem_id_q[wr_idx]  <= win_id_q;
        wr_ptr_q          <= wr_ptr_q + (PTR_W+1)'(1);
      end
      if (!fifo_empty && res.out_ready) beat_q <= pop ? '0 : beat_q + LANE_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      if (rise) begin
        overflow_q <= drop;
        drop_cnt_q <= drop ? 8'd1 : 8'd0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign busy_o         = (state_q == RUN);
  assign overflow_o     = overflow_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign res.out_valid  = !fifo_empty;
  assign res.out_lane   = beat_q;
  assign res.out_count  = mem_cnt_q[rd_idx][beat_q];
  assign res.out_sat    = mem_sat_q[rd_idx][beat_q];
  assign res.out_win_id = mem_id_q[rd_idx];
  assign res.out_last   = !fifo_empty && (beat_q == LAST_LN);

`ifdef PULSE_WIN_PEAK_EN
  logic [IN_W-1:0] peak_q     [NUM_LANES];
  logic [IN_W-1:0] peak_d     [NUM_LANES];
  logic [IN_W-1:0] mem_peak_q [FIFO_DEPTH][NUM_LANES];

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      peak_d[l] = peak_q[l];
      if (acc_en && pulse_in_i[l*IN_W +: IN_W] > peak_q[l]) peak_d[l] = pulse_in_i[l*IN_W +: IN_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LANES; l++) peak_q[l] <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++)
        for (int l = 0; l < NUM_LANES; l++) mem_peak_q[e][l] <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) peak_q[l] <= (active && !close) ? peak_d[l] : '0;
      if (push)
        for (int l = 0; l < NUM_LANES; l++) mem_peak_q[wr_idx][l] <= peak_d[l];
    end
  end

  assign res.out_peak = mem_peak_q[rd_idx][beat_q];
`endif
endmodule

// File: tb/tb_pulse_window_counter_mc.sv
// Directed bench for pulse_window_counter_mc; dut_b uses CNT_W=4 to reach saturation.
module tb_pulse_window_counter_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] pulse_in;
  logic [23:0] window_cycles;
  logic [1:0]  mode;
  logic        count_enable;
  logic        gate;
  logic        rdy;
  logic        busy_a, busy_b, ovf_a, ovf_b;
  logic [7:0]  drop_a, drop_b;

  int checks = 0;
  int errors = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  pulse_window_counter_mc_if #(.LANE_W(2), .CNT_W(24)) ifa ();
  pulse_window_counter_mc_if #(.LANE_W(2), .CNT_W(4))  ifb ();
  assign ifa.out_ready = rdy;
  assign ifb.out_ready = rdy;

  pulse_window_counter_mc #(.CNT_W(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .pulse_in_i(pulse_in),
    .window_cycles_i(window_cycles), .mode_i(mode), .count_enable_i(count_enable), .gate_i(gate),
    .busy_o(busy_a), .overflow_o(ovf_a), .drop_cnt_o(drop_a), .res(ifa));

  pulse_window_counter_mc #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .pulse_in_i(pulse_in),
    .window_cycles_i(window_cycles), .mode_i(mode), .count_enable_i(count_enable), .gate_i(gate),
    .busy_o(busy_b), .overflow_o(ovf_b), .drop_cnt_o(drop_b), .res(ifb));

  always #5 clk = ~clk;

  function automatic logic [63:0] beat(input logic [15:0] id, input logic [1:0] lane, input logic last,
                                       input logic sat, input logic [23:0] cnt);
    return {20'd0, id, lane, last, sat, cnt};
  endfunction

  // Handshakes seen at the falling edge complete on the following rising edge.
  always @(negedge clk) begin
    if (ifa.out_valid && ifa.out_ready)
      qa.push_back(beat(ifa.out_win_id, ifa.out_lane, ifa.out_last, ifa.out_sat, ifa.out_count));
    if (ifb.out_valid && ifb.out_ready)
      qb.push_back(beat(ifb.out_win_id, ifb.out_lane, ifb.out_last, ifb.out_sat, 24'(ifb.out_count)));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_win(input string tag, input bit use_b, input int w, input logic [15:0] id,
                           input logic [3:0][23:0] cnt, input logic sat);
    for (int l = 0; l < 4; l++) begin
      int k;
      logic [63:0] got;
      k   = w * 4 + l;
      got = '1;
      if (use_b) begin
        if (k < qb.size()) got = qb[k];
      end else if (k < qa.size()) begin
        got = qa[k];
      end
      check($sformatf("%s w%0d l%0d", tag, w, l), got, beat(id, 2'(l), l == 3, sat, cnt[l]));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b1; pulse_in = '0; window_cycles = 24'd4; mode = 2'd0;
    count_enable = 1'b0; gate = 1'b0; rdy = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    do_reset();
    check("rst out_valid", 64'(ifa.out_valid), 64'd0);
    check("rst busy",      64'(busy_a),        64'd0);
    check("rst overflow",  64'(ovf_a),         64'd0);
    check("rst drop_cnt",  64'(drop_a),        64'd0);
    check("rst out_count", 64'(ifa.out_count), 64'd0);
    check("rst win_id",    64'(ifa.out_win_id), 64'd0);
    check("rst out_last",  64'(ifa.out_last),  64'd0);

    // Continuous, window 4, lane0 one pulse per cycle: three full windows before abort.
    pulse_in = {5'd0, 5'd0, 5'd0, 5'd1};
    count_enable = 1'b1;
    tick(5);
    check("t1 busy", 64'(busy_a), 64'd1);
    tick(9);
    count_enable = 1'b0;
    tick(20);
    check("t1 beats", 64'(qa.size()), 64'd12);
    for (int w = 0; w < 3; w++) check_win("t1", 1'b0, w, 16'(w), {24'd0, 24'd0, 24'd0, 24'd4}, 1'b0);

    // Window 0: every cycle closes, drain cannot keep up.
    do_reset();
    window_cycles = 24'd0;
    pulse_in = {5'd0, 5'd0, 5'd0, 5'd1};
    count_enable = 1'b1;
    tick(20);
    check("t2 overflow", 64'(ovf_a), 64'd1);
    check("t2 drops",    64'(drop_a != 8'd0), 64'd1);
    check_win("t2", 1'b0, 0, 16'd0, {24'd0, 24'd0, 24'd0, 24'd1}, 1'b0);
    window_cycles = 24'd100;
    count_enable = 1'b0;
    tick(4);
    count_enable = 1'b1;
    tick(4);
    check("t2 overflow cleared", 64'(ovf_a),  64'd0);
    check("t2 drop_cnt cleared", 64'(drop_a), 64'd0);
    count_enable = 1'b0;
    tick(3);

    // Single-shot, window 10, 3 per lane per cycle.
    do_reset();
    mode = 2'd1;
    window_cycles = 24'd10;
    pulse_in = {5'd3, 5'd3, 5'd3, 5'd3};
    count_enable = 1'b1;
    tick(5);
    check("t3 busy running", 64'(busy_a), 64'd1);
    tick(9);
    check("t3 busy fallen", 64'(busy_a), 64'd0);
    tick(20);
    check("t3 beats", 64'(qa.size()), 64'd4);
    check_win("t3", 1'b0, 0, 16'd0, {24'd30, 24'd30, 24'd30, 24'd30}, 1'b0);
    count_enable = 1'b0;
    tick(3);

    // Gated, window 8: gate high for three cycles, then a fully gated-off window.
    do_reset();
    mode = 2'd2;
    window_cycles = 24'd8;
    pulse_in = {5'd2, 5'd2, 5'd2, 5'd2};
    count_enable = 1'b1;
    tick(1);
    gate = 1'b1;
    tick(3);
    gate = 1'b0;
    tick(14);
    count_enable = 1'b0;
    tick(20);
    check("t4 beats", 64'(qa.size()), 64'd8);
    check_win("t4", 1'b0, 0, 16'd0, {24'd6, 24'd6, 24'd6, 24'd6}, 1'b0);
    check_win("t4", 1'b0, 1, 16'd1, {24'd0, 24'd0, 24'd0, 24'd0}, 1'b0);

    // Saturation on the 4-bit accumulator, then a clean window.
    do_reset();
    window_cycles = 24'd4;
    pulse_in = {5'd16, 5'd16, 5'd16, 5'd16};
    count_enable = 1'b1;
    tick(5);
    pulse_in = '0;
    tick(5);
    count_enable = 1'b0;
    tick(20);
    check("t5 beats b", 64'(qb.size()), 64'd8);
    check_win("t5b", 1'b1, 0, 16'd0, {24'd15, 24'd15, 24'd15, 24'd15}, 1'b1);
    check_win("t5b", 1'b1, 1, 16'd1, {24'd0, 24'd0, 24'd0, 24'd0}, 1'b0);
    check_win("t5a", 1'b0, 0, 16'd0, {24'd64, 24'd64, 24'd64, 24'd64}, 1'b0);

    // Stalled output: four windows buffered, fifth aborted mid-window, then drained.
    do_reset();
    rdy = 1'b0;
    window_cycles = 24'd4;
    pulse_in = {5'd4, 5'd3, 5'd2, 5'd1};
    count_enable = 1'b1;
    tick(10);
    check("t6 head valid", 64'(ifa.out_valid), 64'd1);
    check("t6 head count", 64'(ifa.out_count), 64'd4);
    tick(8);
    count_enable = 1'b0;
    tick(3);
    check("t6 head stable", 64'(ifa.out_count), 64'd4);
    check("t6 busy",        64'(busy_a), 64'd0);
    check("t6 overflow",    64'(ovf_a),  64'd0);
    rdy = 1'b1;
    tick(25);
    check("t6 beats", 64'(qa.size()), 64'd16);
    for (int w = 0; w < 4; w++) check_win("t6", 1'b0, w, 16'(w), {24'd16, 24'd12, 24'd8, 24'd4}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
